// File: rtl/aes_pkg.sv
// Shared AES definitions: GF(2^8) helpers, datapath widths and the MixColumns FSM encoding.
package aes_pkg;

    localparam int AES_STATE_W = 128;
    localparam int AES_COL_W   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } mc_state_e;

    typedef struct packed {
        logic bypass;
        logic dec;
    } mc_mode_t;

    function automatic logic [7:0] xt2(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    // Constants of MixColumns never exceed 4 bits, so four doublings cover every product.
    function automatic logic [7:0] gf_mul4(input logic [7:0] a, input logic [3:0] c);
        logic [7:0] p;
        logic [7:0] m;
        p = 8'h00;
        m = a;
        for (int i = 0; i < 4; i++) begin
            if (c[i]) p = p ^ m;
            m = xt2(m);
        end
        return p;
    endfunction

endpackage

// File: rtl/aes_mixcolumn_lane.sv
// One MixColumns column lane: forward or inverse mix of a single 32-bit column, purely combinational.
module aes_mixcolumn_lane
    import aes_pkg::*;
(
    input  logic [AES_COL_W-1:0] col_i,
    input  logic                 dec_i,
    output logic [AES_COL_W-1:0] col_o
);

    logic [7:0] row_s [4];

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            row_s[r] = col_i[8*r +: 8];
        end
    end

    always_comb begin
        col_o = '0;
        for (int r = 0; r < 4; r++) begin
            if (dec_i) begin
                col_o[8*r +: 8] = gf_mul4(row_s[r], 4'he)
                                ^ gf_mul4(row_s[(r+1)%4], 4'hb)
                                ^ gf_mul4(row_s[(r+2)%4], 4'hd)
                                ^ gf_mul4(row_s[(r+3)%4], 4'h9);
            end else begin
                col_o[8*r +: 8] = gf_mul4(row_s[r], 4'h2)
                                ^ gf_mul4(row_s[(r+1)%4], 4'h3)
                                ^ row_s[(r+2)%4]
                                ^ row_s[(r+3)%4];
            end
        end
    end

endmodule

// File: rtl/aes_mixcolumns_seq.sv
// Sequential MixColumns over a full AES state, LANES columns per beat, with valid/ready on both sides.
module aes_mixcolumns_seq
    import aes_pkg::*;
#(
    parameter int LANES = 1
) (
    input  logic                   g_clk,
    input  logic                   g_reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [AES_STATE_W-1:0] in_state,
    input  logic                   in_dec,
    input  logic                   in_bypass,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [AES_STATE_W-1:0] out_state
);

    localparam int N  = 4 / LANES;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] BEAT_LAST = CW'(N - 1);

    if (!(LANES == 1 || LANES == 2 || LANES == 4)) begin : g_bad_lanes
        $error("aes_mixcolumns_seq: LANES must be 1, 2 or 4");
    end

    mc_state_e              state_q;
    logic [CW-1:0]          beat_q;
    logic [AES_STATE_W-1:0] work_q;
    mc_mode_t               mode_q;
    logic                   out_valid_q;

    logic [AES_COL_W-1:0]   lane_in_s  [LANES];
    logic [AES_COL_W-1:0]   lane_out_s [LANES];
    logic [AES_STATE_W-1:0] mixed_s;

    // In DONE the slot frees up in the same cycle the consumer takes the result.
    always_comb begin
        case (state_q)
            ST_IDLE: in_ready = 1'b1;
            ST_DONE: in_ready = out_ready;
            default: in_ready = 1'b0;
        endcase
    end

    always_comb begin
        mixed_s = work_q;
        for (int j = 0; j < LANES; j++) begin
            lane_in_s[j] = work_q[AES_COL_W*(int'(beat_q)*LANES + j) +: AES_COL_W];
            mixed_s[AES_COL_W*(int'(beat_q)*LANES + j) +: AES_COL_W] = lane_out_s[j];
        end
    end

    for (genvar j = 0; j < LANES; j++) begin : g_lane
        aes_mixcolumn_lane u_lane (
            .col_i (lane_in_s[j]),
            .dec_i (mode_q.dec),
            .col_o (lane_out_s[j])
        );
    end

    always_ff @(posedge g_clk) begin
        if (g_reset) begin
            state_q     <= ST_IDLE;
            beat_q      <= '0;
            work_q      <= '0;
            mode_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (in_valid) begin
                        work_q      <= in_state;
                        mode_q      <= '{bypass: in_bypass, dec: in_dec};
                        beat_q      <= '0;
                        state_q     <= in_bypass ? ST_DONE : ST_BUSY;
                        out_valid_q <= in_bypass;
                    end
                end
                ST_BUSY: begin
                    if (!mode_q.bypass) work_q <= mixed_s;
                    if (beat_q == BEAT_LAST) begin
                        state_q     <= ST_DONE;
                        out_valid_q <= 1'b1;
                    end else begin
                        beat_q <= beat_q + CW'(1);
                    end
                end
                ST_DONE: begin
                    // Accepting the next state while the result leaves avoids an IDLE bubble.
                    if (out_ready) begin
                        if (in_valid) begin
                            work_q      <= in_state;
                            mode_q      <= '{bypass: in_bypass, dec: in_dec};
                            beat_q      <= '0;
                            state_q     <= in_bypass ? ST_DONE : ST_BUSY;
                            out_valid_q <= in_bypass;
                        end else begin
                            state_q     <= ST_IDLE;
                            out_valid_q <= 1'b0;
                        end
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_state = work_q;

endmodule

// File: doc/aes_mixcolumns_seq.md
# aes_mixcolumns_seq

Sequential, parametrised MixColumns engine for a full 128-bit AES state. It applies forward or inverse MixColumns to all four columns of a state, LANES columns per cycle, or passes the state through unchanged in bypass mode (final round). It sits between the SubBytes/ShiftRows stage and the AddRoundKey stage of the round datapath, and uses a valid/ready handshake on both sides.

## Interface
Parameters:
- LANES, 1: columns processed per cycle. Legal values are 1, 2 and 4; any other value is an elaboration error.

Ports:
- g_clk  in  1  clock; all state changes on the rising edge.
- g_reset  in  1  synchronous, active-high reset.
- in_valid  in  1  input state offered.
- in_ready  out  1  block can accept a state.
- in_state  in  128  column c at [32c+31:32c]; row r of a column at [8r+7:8r].
- in_dec  in  1  1 = inverse MixColumns, 0 = forward.
- in_bypass  in  1  1 = output equals input, no mixing; overrides in_dec.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_state  out  128  result, same layout as in_state.

## Operation
- Definitions: N = 4/LANES beats per state. Handshake in = in_valid & in_ready. Handshake out = out_valid & out_ready.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - in_ready = 1.
  - On handshake in, capture in_state into the work register and latch in_dec and in_bypass. The latched mode holds for the whole operation.
  - With bypass set, go to DONE. Otherwise clear the beat counter and go to BUSY.
- BUSY:
  - in_ready = 0.
  - Beat k (0..N-1) transforms columns k·LANES .. k·LANES+LANES-1 of the work register in place. Other columns are untouched.
  - After beat N-1, go to DONE.
- DONE:
  - out_valid = 1; out_state = work register, held stable until handshake out.
  - in_ready = out_ready.
  - Handshake out with no handshake in: go to IDLE.
  - Handshake out and handshake in in the same cycle: capture the new state and go straight to BUSY (or stay in DONE if the new state is bypassed). No idle bubble.
- Column arithmetic is GF(2^8) with reduction polynomial 0x11b. With rows a0..a3, the output row r is:
  - Forward: 2·a_r ⊕ 3·a_{r+1} ⊕ a_{r+2} ⊕ a_{r+3}.
  - Inverse: e·a_r ⊕ b·a_{r+1} ⊕ d·a_{r+2} ⊕ 9·a_{r+3}.
  - Indices are mod 4.
- Beat counter width is max(1, log2(N)). It wraps only by leaving BUSY; it is never compared past N-1.
- in_dec and in_bypass are ignored outside handshake in.

## Timing
- Reset values:
  - state IDLE, in_ready = 1.
  - out_valid = 0, out_state = 128'h0.
  - Beat counter 0, latched mode 0.
- Latency, measured from the cycle handshake in occurs:
  - Mixing: out_valid is first high N+1 cycles later (LANES=4: 2, LANES=2: 3, LANES=1: 5).
  - Bypass: out_valid is first high 1 cycle later.
- Throughput with out_ready held high: one state per N+1 cycles.
- Back-pressure: out_valid may stay high indefinitely. out_state must not change while it does.
- Reset mid-operation, in any state, takes effect on the next edge: the FSM returns to IDLE, out_valid drops, and the partial result is discarded and cleared. A handshake in during the reset cycle is ignored.
- No combinational path from in_valid to in_ready. out_ready feeds in_ready combinationally in DONE only.

## Structure
- Shared package aes_pkg holds:
  - xt2 (multiply by 2 mod 0x11b) and gf_mul4 (multiply by a 4-bit constant) functions.
  - Constants AES_STATE_W = 128 and AES_COL_W = 32.
  - The FSM state enum.
- One combinational sub-module: aes_mixcolumn_lane (32-bit column in, dec in, 32-bit column out). It is instantiated LANES times.
  - Lane j in beat k is fed by a LANES-way column mux selected by the beat counter.
  - Its output is written back to column k·LANES+j.
- Top level contains only the FSM, the beat counter, the work register and the lane muxing.

## Test plan
- Forward, LANES=1: in_state columns 0..3 all 32'h455313db → every output column is 32'hbca14d8e. out_valid rises exactly 5 cycles after handshake in.
- Inverse: input columns 32'hbca14d8e and 32'h9d58dc9f → outputs 32'h455313db and 32'h5c220af2. Repeat for LANES=1, 2 and 4 and check the latency is 5, 3 and 2 respectively.
- Fixed points and bypass:
  - 32'hc6c6c6c6 and 32'h01010101 columns are unchanged in both modes.
  - Bypass with in_state = 128'h0123…cdef → identical output, 1 cycle later.
- Back-pressure and back-to-back: hold out_ready=0 for 10 cycles → out_state stable and in_ready=0. Then assert out_ready with in_valid high → new state accepted in the same cycle, and the next result is correct with no IDLE cycle.
- Reset: assert g_reset during BUSY beat 1 → next cycle is IDLE with out_valid=0 and out_state=0. A subsequent state processes correctly.
- Random: 1000 random states with random dec/bypass and random out_ready against a software model. Also check that inverse(forward(x)) = x.
